// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and forwarding control for a 5-stage pipe.
// Macro PIPE_HAZARD_FORWARD_EN: forwarding + load-use; undefined: RAW interlock.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  idRn,
    input  logic [4:0]  idRm,
    input  logic        idUsesRn,
    input  logic        idUsesRm,
    input  logic [4:0]  idexRd,
    input  logic        idexRegWrite,
    input  logic        idexMemRead,
    input  logic [4:0]  exmemRd,
    input  logic        exmemRegWrite,
    input  logic [4:0]  memwbRd,
    input  logic        memwbRegWrite,
    input  logic        branchTaken,
    input  logic        memReq,
    input  logic        memReady,
    output logic        pcEn,
    output logic        ifidEn,
    output logic        idexEn,
    output logic        exmemEn,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        memwbFlush,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic [1:0]  state,
    output logic [15:0] stallCycles
);
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        HAZWAIT = 2'b10
    } state_t;

    state_t st;
    logic   memHold;
    logic   rnLive;
    logic   rmLive;
    logic   idexWr;
    logic   exmemWr;
    logic   idexHit;
    logic   hazStall;

    assign memHold = memReq && !memReady;
    assign rnLive  = idUsesRn && (idRn != XZR);
    assign rmLive  = idUsesRm && (idRm != XZR);
    assign idexWr  = idexRegWrite && (idexRd != XZR);
    assign exmemWr = exmemRegWrite && (exmemRd != XZR);
    assign idexHit = idexWr &&
                     ((rnLive && idexRd == idRn) ||
                      (rmLive && idexRd == idRm));

`ifdef PIPE_HAZARD_FORWARD_EN
    logic memwbWr;

    assign memwbWr  = memwbRegWrite && (memwbRd != XZR);
    // only a load still in EX cannot be forwarded in time
    assign hazStall = idexMemRead && idexHit;

    // forward mux select; younger EX/MEM result beats MEM/WB
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (!reset) begin
            if (exmemWr && exmemRd == idRn)
                forwardA = 2'b10;
            else if (memwbWr && memwbRd == idRn)
                forwardA = 2'b01;
            if (exmemWr && exmemRd == idRm)
                forwardB = 2'b10;
            else if (memwbWr && memwbRd == idRm)
                forwardB = 2'b01;
        end
    end
`else
    logic exmemHit;
    logic unused_wb;

    // MEM/WB never interlocks: the register file writes before it is read
    assign unused_wb = ^{memwbRd, memwbRegWrite, idexMemRead};
    assign exmemHit  = exmemWr &&
                       ((rnLive && exmemRd == idRn) ||
                        (rmLive && exmemRd == idRm));
    assign hazStall  = idexHit || exmemHit;
    assign forwardA  = 2'b00;
    assign forwardB  = 2'b00;
`endif

    // enables and bubbles: reset > memory hold > branch > data hazard
    always_comb begin
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        memwbFlush = 1'b0;
        if (reset) begin
            pcEn = 1'b1;
        end else if (memHold) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            memwbFlush = 1'b1;
        end else if (branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (hazStall) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
        end
    end

    // state tracks why the previous cycle stalled; counter saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= RUN;
            stallCycles <= 16'd0;
        end else begin
            if (!pcEn && stallCycles != 16'hFFFF)
                stallCycles <= stallCycles + 16'd1;
            if (memHold)
                st <= MEMWAIT;
            else if (branchTaken)
                st <= RUN;
            else if (hazStall && !idexMemRead)
                st <= HAZWAIT;
`ifndef PIPE_HAZARD_FORWARD_EN
            else if (hazStall)
                st <= HAZWAIT;
`endif
            else
                st <= RUN;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Honours PIPE_HAZARD_FORWARD_EN to pick the expected build behaviour.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] E_ALL = 4'b1111;
    localparam logic [3:0] E_STL = 4'b0011;
    localparam logic [3:0] E_NO  = 4'b0000;
    localparam logic [2:0] F_NO  = 3'b000;
    localparam logic [2:0] F_BR  = 3'b110;
    localparam logic [2:0] F_ST  = 3'b010;
    localparam logic [2:0] F_MW  = 3'b001;
    localparam logic [1:0] FW0   = 2'b00;
    localparam logic [1:0] FWB   = 2'b01;
    localparam logic [1:0] FWX   = 2'b10;
    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] MW    = 2'b01;
    localparam logic [1:0] HW    = 2'b10;

    typedef struct packed {
        logic       rst;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urn;
        logic       urm;
        logic [4:0] xRd;
        logic       xRW;
        logic       xMR;
        logic [4:0] mRd;
        logic       mRW;
        logic [4:0] wRd;
        logic       wRW;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        string       nm;
        logic [28:0] v;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  idRn, idRm;
    logic        idUsesRn, idUsesRm;
    logic [4:0]  idexRd;
    logic        idexRegWrite, idexMemRead;
    logic [4:0]  exmemRd;
    logic        exmemRegWrite;
    logic [4:0]  memwbRd;
    logic        memwbRegWrite;
    logic        branchTaken, memReq, memReady;
    logic        pcEn, ifidEn, idexEn, exmemEn;
    logic        ifidFlush, idexFlush, memwbFlush;
    logic [1:0]  forwardA, forwardB, state;
    logic [15:0] stallCycles;
    logic [28:0] obs;

    exp_t        sbq[$];
    logic [15:0] esc;
    int          tests;
    int          fails;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .idRn(idRn), .idRm(idRm),
        .idUsesRn(idUsesRn), .idUsesRm(idUsesRm),
        .idexRd(idexRd), .idexRegWrite(idexRegWrite),
        .idexMemRead(idexMemRead),
        .exmemRd(exmemRd), .exmemRegWrite(exmemRegWrite),
        .memwbRd(memwbRd), .memwbRegWrite(memwbRegWrite),
        .branchTaken(branchTaken), .memReq(memReq),
        .memReady(memReady),
        .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn),
        .exmemEn(exmemEn),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush),
        .memwbFlush(memwbFlush),
        .forwardA(forwardA), .forwardB(forwardB),
        .state(state), .stallCycles(stallCycles)
    );

    assign obs = {pcEn, ifidEn, idexEn, exmemEn,
                  ifidFlush, idexFlush, memwbFlush,
                  forwardA, forwardB, state, stallCycles};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [12:0] ex(logic [3:0] en, logic [2:0] fl,
                                       logic [1:0] fa, logic [1:0] fb,
                                       logic [1:0] st);
        return {en, fl, fa, fb, st};
    endfunction

    task automatic apply(stim_t s);
        reset         = s.rst;
        idRn          = s.rn;
        idRm          = s.rm;
        idUsesRn      = s.urn;
        idUsesRm      = s.urm;
        idexRd        = s.xRd;
        idexRegWrite  = s.xRW;
        idexMemRead   = s.xMR;
        exmemRd       = s.mRd;
        exmemRegWrite = s.mRW;
        memwbRd       = s.wRd;
        memwbRegWrite = s.wRW;
        branchTaken   = s.br;
        memReq        = s.req;
        memReady      = s.rdy;
    endtask

    // expected record; esc models the stall counter across edges
    task automatic push(string nm, stim_t s, logic [12:0] x);
        exp_t e;
        e.nm = nm;
        e.v  = {x, esc};
        sbq.push_back(e);
        if (s.rst)
            esc = 16'd0;
        else if (!x[12] && esc != 16'hFFFF)
            esc = esc + 16'd1;
    endtask

    task automatic do_reset();
        stim_t s;
        s = nop();
        s.rst = 1'b1;
        apply(s);
        @(posedge clk);
        #1;
        esc = 16'd0;
        apply(nop());
    endtask

    task automatic test_reset();
        stim_t s[2];
        logic [12:0] x[2];
        exp_t e;
        s[0] = nop();
        s[0].rst = 1'b1;
        apply(s[0]);
        repeat (2) @(posedge clk);
        #1;
        esc = 16'd0;
        s[0].req = 1'b1; s[0].br = 1'b1;
        s[0].xRd = 5; s[0].xRW = 1'b1; s[0].xMR = 1'b1;
        s[0].rn = 5; s[0].urn = 1'b1;
        s[0].mRd = 5; s[0].mRW = 1'b1;
        x[0] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        s[1] = nop();
        x[1] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("reset", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[4];
        logic [12:0] x[4];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].xRd = 5; s[0].xRW = 1'b1; s[0].xMR = 1'b1;
        s[0].rn = 5; s[0].urn = 1'b1;
        x[0] = ex(E_STL, F_ST, FW0, FW0, RUN);
        s[1] = nop();
        s[1].rn = 5; s[1].urn = 1'b1;
        s[1].mRd = 5; s[1].mRW = 1'b1;
        x[1] = FWD ? ex(E_ALL, F_NO, FWX, FW0, RUN)
                   : ex(E_STL, F_ST, FW0, FW0, HW);
        s[2] = nop();
        s[2].rn = 5; s[2].urn = 1'b1;
        s[2].wRd = 5; s[2].wRW = 1'b1;
        x[2] = FWD ? ex(E_ALL, F_NO, FWB, FW0, RUN)
                   : ex(E_ALL, F_NO, FW0, FW0, HW);
        s[3] = nop();
        x[3] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("load_use", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[5];
        logic [12:0] x[5];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].req = 1'b1;
        x[0] = ex(E_NO, F_MW, FW0, FW0, RUN);
        s[1] = s[0];
        s[1].br = 1'b1;
        s[1].xRd = 5; s[1].xRW = 1'b1; s[1].xMR = 1'b1;
        s[1].rn = 5; s[1].urn = 1'b1;
        x[1] = ex(E_NO, F_MW, FW0, FW0, MW);
        s[2] = s[0];
        x[2] = ex(E_NO, F_MW, FW0, FW0, MW);
        s[3] = s[0];
        s[3].rdy = 1'b1;
        x[3] = ex(E_ALL, F_NO, FW0, FW0, MW);
        s[4] = nop();
        x[4] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("mem_wait", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_vs_load_use();
        stim_t s[4];
        logic [12:0] x[4];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].br = 1'b1;
        s[0].xRd = 5; s[0].xRW = 1'b1; s[0].xMR = 1'b1;
        s[0].rn = 5; s[0].urn = 1'b1;
        x[0] = ex(E_ALL, F_BR, FW0, FW0, RUN);
        s[1] = nop();
        s[1].mRd = 3; s[1].mRW = 1'b1;
        s[1].rn = 3; s[1].urn = 1'b1;
        x[1] = FWD ? ex(E_ALL, F_NO, FWX, FW0, RUN)
                   : ex(E_STL, F_ST, FW0, FW0, RUN);
        s[2] = s[1];
        s[2].br = 1'b1;
        x[2] = FWD ? ex(E_ALL, F_BR, FWX, FW0, RUN)
                   : ex(E_ALL, F_BR, FW0, FW0, HW);
        s[3] = nop();
        x[3] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("branch_vs_lu", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_xzr();
        stim_t s[4];
        logic [12:0] x[4];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].xRd = 31; s[0].xRW = 1'b1; s[0].xMR = 1'b1;
        s[0].rn = 31; s[0].urn = 1'b1;
        s[0].rm = 31; s[0].urm = 1'b1;
        s[0].mRd = 31; s[0].mRW = 1'b1;
        s[0].wRd = 31; s[0].wRW = 1'b1;
        x[0] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        s[1] = nop();
        s[1].xRd = 7; s[1].xMR = 1'b1;
        s[1].mRd = 7; s[1].wRd = 7;
        s[1].rn = 7; s[1].urn = 1'b1;
        s[1].rm = 7; s[1].urm = 1'b1;
        x[1] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        s[2] = nop();
        s[2].xRd = 5; s[2].xRW = 1'b1; s[2].xMR = 1'b1;
        s[2].rn = 5;
        x[2] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        s[3] = nop();
        x[3] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("xzr", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fwd_priority();
        stim_t s[4];
        logic [12:0] x[4];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].mRd = 7; s[0].mRW = 1'b1;
        s[0].wRd = 7; s[0].wRW = 1'b1;
        s[0].rm = 7; s[0].urm = 1'b1;
        x[0] = FWD ? ex(E_ALL, F_NO, FW0, FWX, RUN)
                   : ex(E_STL, F_ST, FW0, FW0, RUN);
        s[1] = nop();
        s[1].mRd = 7; s[1].mRW = 1'b1;
        s[1].wRd = 9; s[1].wRW = 1'b1;
        s[1].rn = 9; s[1].urn = 1'b1;
        s[1].rm = 7; s[1].urm = 1'b1;
        x[1] = FWD ? ex(E_ALL, F_NO, FWB, FWX, RUN)
                   : ex(E_STL, F_ST, FW0, FW0, HW);
        s[2] = nop();
        s[2].wRd = 9; s[2].wRW = 1'b1;
        s[2].rn = 9; s[2].urn = 1'b1;
        x[2] = FWD ? ex(E_ALL, F_NO, FWB, FW0, RUN)
                   : ex(E_ALL, F_NO, FW0, FW0, HW);
        s[3] = nop();
        x[3] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("fwd_priority", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_memwait();
        stim_t s[4];
        logic [12:0] x[4];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].req = 1'b1;
        x[0] = ex(E_NO, F_MW, FW0, FW0, RUN);
        s[1] = s[0];
        x[1] = ex(E_NO, F_MW, FW0, FW0, MW);
        s[2] = s[0];
        s[2].rst = 1'b1; s[2].br = 1'b1;
        s[2].mRd = 3; s[2].mRW = 1'b1;
        s[2].rn = 3; s[2].urn = 1'b1;
        x[2] = ex(E_ALL, F_NO, FW0, FW0, MW);
        s[3] = nop();
        x[3] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("reset_memwait", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hazwait();
        stim_t s[7];
        logic [12:0] x[7];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].mRd = 3; s[0].mRW = 1'b1;
        s[0].rn = 3; s[0].urn = 1'b1;
        x[0] = FWD ? ex(E_ALL, F_NO, FWX, FW0, RUN)
                   : ex(E_STL, F_ST, FW0, FW0, RUN);
        s[1] = nop();
        x[1] = ex(E_ALL, F_NO, FW0, FW0, FWD ? RUN : HW);
        s[2] = nop();
        x[2] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        s[3] = nop();
        s[3].xRd = 4; s[3].xRW = 1'b1;
        s[3].rn = 4; s[3].urn = 1'b1;
        x[3] = FWD ? ex(E_ALL, F_NO, FW0, FW0, RUN)
                   : ex(E_STL, F_ST, FW0, FW0, RUN);
        s[4] = s[3];
        s[4].req = 1'b1;
        x[4] = ex(E_NO, F_MW, FW0, FW0, FWD ? RUN : HW);
        s[5] = nop();
        x[5] = ex(E_ALL, F_NO, FW0, FW0, MW);
        s[6] = nop();
        x[6] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("hazwait", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        stim_t s[3];
        logic [12:0] x[3];
        exp_t e;
        do_reset();
        s[0] = nop();
        s[0].req = 1'b1;
        apply(s[0]);
        repeat (65536) @(posedge clk);
        #1;
        esc = 16'hFFFF;
        x[0] = ex(E_NO, F_MW, FW0, FW0, MW);
        s[1] = nop();
        x[1] = ex(E_ALL, F_NO, FW0, FW0, MW);
        s[2] = nop();
        x[2] = ex(E_ALL, F_NO, FW0, FW0, RUN);
        foreach (s[i]) begin
            apply(s[i]);
            push("saturation", s[i], x[i]);
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s step %0d: got %h want %h", e.nm, i, obs, e.v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        esc   = 16'd0;
        apply(nop());
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_vs_load_use();
        test_xzr();
        test_fwd_priority();
        test_reset_memwait();
        test_hazwait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
